// File: rtl/tff_count_pkg.sv
// ---------------------------------------------------------------------------
// Package: tff_count_pkg
// Purpose: shared types and constants for the T flip-flop modulo counter
//          controller (tff_count_ctrl) and its cell (tff_cell).
// Contents:
//   state_t   controller FSM states (ST_DONE used only when the one-shot
//             option TFF_COUNT_CTRL_ONESHOT_EN is compiled in)
//   DIR_UP    dir input value for counting up
//   DIR_DOWN  dir input value for counting down
// ---------------------------------------------------------------------------
package tff_count_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage : tff_count_pkg

// File: rtl/tff_cell.sv
// ---------------------------------------------------------------------------
// Module: tff_cell
// Purpose: a single T flip-flop; q inverts on every clock edge where t=1.
// Ports:
//   clk  in  1  clock, state updates on posedge
//   rst  in  1  synchronous reset, active-high, clears q to 0
//   t    in  1  toggle enable
//   q    out 1  flip-flop output
// ---------------------------------------------------------------------------
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    logic r_q;

    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would race between flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 1'b0;
        end else if (t) begin
            r_q <= ~r_q;
        end
    end

    assign q = r_q;

endmodule : tff_cell

// File: rtl/tff_count_ctrl.sv
// ---------------------------------------------------------------------------
// Module: tff_count_ctrl
// Purpose: sequences a bank of WIDTH T flip-flops as a programmable modulo
//          up/down counter. Every cycle the controller computes the per-bit
//          toggle vector t_vec from the current count, direction, captured
//          limit, load and hold; the bank then does q <= q ^ t_vec.
// Parameters:
//   WIDTH     counter width / number of T flip-flops (>= 2)
// Ports:
//   clk       in   1      clock, all state updates on posedge
//   rst       in   1      synchronous reset, active-high
//   start     in   1      IDLE->RUN, captures limit
//   stop      in   1      RUN->IDLE, count retained
//   hold      in   1      in RUN: freeze count, stay in RUN
//   dir       in   1      0=up, 1=down, sampled every cycle
//   load      in   1      force q to load_val on next edge, any state
//   load_val  in   WIDTH  value for load
//   limit     in   WIDTH  modulo top value, captured on start
//   q         out  WIDTH  T flip-flop bank outputs (the count)
//   t_vec     out  WIDTH  toggle enables applied this cycle (combinational)
//   running   out  1      high while the FSM is in RUN
//   wrap      out  1      one-cycle pulse in the cycle q shows a wrapped value
//   done      out  1      one-shot completion pulse (0 unless option built)
// Build option:
//   TFF_COUNT_CTRL_ONESHOT_EN  when defined, the first wrap after start ends
//                              the run through a one-cycle DONE state.
// Per-cycle priority: rst > load > stop > start > hold > count.
// ---------------------------------------------------------------------------
module tff_count_ctrl
    import tff_count_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] t_vec,
    output logic             running,
    output logic             wrap,
    output logic             done
);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_limit;
    logic               r_wrap;
    logic               w_wrap_next;
    logic               w_capture;
    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   w_t_vec;
    logic [WIDTH-1:0]   w_up_t;
    logic [WIDTH-1:0]   w_down_t;
    logic               w_at_top;
    logic               w_at_bottom;
`ifdef TFF_COUNT_CTRL_ONESHOT_EN
    logic               r_done;
    logic               w_done_next;
`endif

    // -----------------------------------------------------------------------
    // Counter storage: one T flip-flop per bit, nothing else writes q.
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        tff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .t   (w_t_vec[gi]),
            .q   (w_q[gi])
        );
    end

    // -----------------------------------------------------------------------
    // Binary count toggles: bit i toggles when all lower bits are 1 (up) or
    // all lower bits are 0 (down). The running carries build &q[i-1:0] and
    // &~q[i-1:0] without variable part-selects.
    // -----------------------------------------------------------------------
    always_comb begin : p_count_toggles
        logic up_carry;
        logic dn_carry;
        up_carry = 1'b1;
        dn_carry = 1'b1;
        w_up_t   = '0;
        w_down_t = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_up_t[i]   = up_carry;
            w_down_t[i] = dn_carry;
            up_carry    = up_carry & w_q[i];
            dn_carry    = dn_carry & ~w_q[i];
        end
    end

    // All-ones is always a wrap point so a loaded value above the limit
    // still returns to 0 instead of running off the top.
    assign w_at_top    = (w_q == r_limit) || (&w_q);
    assign w_at_bottom = (w_q == '0);

    // -----------------------------------------------------------------------
    // Next-state and toggle selection.
    // -----------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_t_vec      = '0;
        w_wrap_next  = 1'b0;
        w_capture    = 1'b0;
`ifdef TFF_COUNT_CTRL_ONESHOT_EN
        w_done_next  = 1'b0;
`endif
        if (rst) begin
            // bank is being cleared; keep toggles quiet
            w_state_next = ST_IDLE;
        end else if (load) begin
            // q ^ (q ^ load_val) == load_val; the FSM stays where it is,
            // except that DONE always falls back to IDLE.
            w_t_vec = w_q ^ load_val;
            if (r_state == ST_DONE) begin
                w_state_next = ST_IDLE;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_next = ST_RUN;
                        w_capture    = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        w_state_next = ST_IDLE;
                    end else if (hold) begin
                        w_t_vec = '0;
                    end else if ((dir == DIR_UP) ? w_at_top : w_at_bottom) begin
                        // up: clear every set bit; down: q is 0, so toggling
                        // the limit bits lands exactly on the limit.
                        w_t_vec     = (dir == DIR_UP) ? w_q : r_limit;
                        w_wrap_next = 1'b1;
`ifdef TFF_COUNT_CTRL_ONESHOT_EN
                        w_state_next = ST_DONE;
                        w_done_next  = 1'b1;
`endif
                    end else begin
                        w_t_vec = (dir == DIR_UP) ? w_up_t : w_down_t;
                    end
                end
                ST_DONE: begin
                    w_state_next = ST_IDLE;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Controller registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_limit <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_wrap  <= w_wrap_next;
            if (w_capture) begin
                r_limit <= limit;
            end
        end
    end

`ifdef TFF_COUNT_CTRL_ONESHOT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_done_next;
        end
    end
    assign done = r_done;
`else
    assign done = 1'b0;
`endif

    assign q       = w_q;
    assign t_vec   = w_t_vec;
    assign running = (r_state == ST_RUN);
    assign wrap    = r_wrap;

endmodule : tff_count_ctrl
